// File: rtl/grid_write_arbiter.sv
// grid_write_arbiter: shares the single character-grid write port
// (tg_we/tg_addr/tg_input) between the terminal controller and the processor
// MMIO writer, and sequences a full-grid clear with CLEAR_CHAR.
// Grants are combinational (ready-style) so a requester can present its next
// write in the grant cycle; the grid write follows one cycle later from
// registered outputs.
// Optional build macro: GRID_ARB_FIXED_PRIO_EN -- terminal always wins ties
// (no round-robin pointer). Default build: round-robin between requesters.
module grid_write_arbiter #(
  parameter int         SCREEN_WIDTH  = 76,
  parameter int         SCREEN_HEIGHT = 256,
  parameter logic [7:0] CLEAR_CHAR    = 8'h20,
  parameter int         ADDR_W        = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic              term_req,
  input  logic [ADDR_W-1:0] term_addr,
  input  logic [7:0]        term_data,
  output logic              term_gnt,
  input  logic              proc_req,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [7:0]        proc_data,
  output logic              proc_gnt,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              oor_drop,
  output logic              tg_we,
  output logic [ADDR_W-1:0] tg_addr,
  output logic [7:0]        tg_input
);

  localparam int GRID_CELLS = SCREEN_WIDTH * SCREEN_HEIGHT;
  // One bit wider than an address so the cell count itself is representable.
  localparam logic [ADDR_W:0] CELLS_EXT = (ADDR_W + 1)'(GRID_CELLS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   clear_cnt;
  logic              term_win;
  logic              proc_win;
  logic [ADDR_W-1:0] win_addr;
  logic [7:0]        win_data;
  logic              win_in_range;

`ifndef GRID_ARB_FIXED_PRIO_EN
  // High when the processor should win the next tie (terminal granted last).
  logic favour_proc;
`endif

  // Pick at most one winner per cycle; only in IDLE and never when a clear starts.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned -- that is what keeps a combinational block from inferring a latch.
    term_win = 1'b0;
    proc_win = 1'b0;
    if (state == ST_IDLE && !clear_start) begin
      if (term_req && proc_req) begin
`ifdef GRID_ARB_FIXED_PRIO_EN
        term_win = 1'b1;
`else
        term_win = !favour_proc;
        proc_win = favour_proc;
`endif
      end else begin
        term_win = term_req;
        proc_win = proc_req;
      end
    end
  end

  assign win_addr     = proc_win ? proc_addr : term_addr;
  assign win_data     = proc_win ? proc_data : term_data;
  assign win_in_range = ({1'b0, win_addr} < CELLS_EXT);

  // Grants are forced low while reset is asserted so all outputs read 0 at once.
  assign term_gnt = rst_in & term_win;
  assign proc_gnt = rst_in & proc_win;

`ifndef GRID_ARB_FIXED_PRIO_EN
  // Round-robin pointer: favour whichever requester was not granted most recently.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      favour_proc <= 1'b0;
    end else if (term_win) begin
      favour_proc <= 1'b1;
    end else if (proc_win) begin
      favour_proc <= 1'b0;
    end
  end
`endif

  // Main FSM: registered grid write from a grant, or the clear address sweep.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order in this block.
    if (!rst_in) begin
      state      <= ST_IDLE;
      clear_cnt  <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      oor_drop   <= 1'b0;
      tg_we      <= 1'b0;
      tg_addr    <= '0;
      tg_input   <= '0;
    end else begin
      tg_we      <= 1'b0;
      oor_drop   <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            state      <= ST_CLEAR;
            clear_busy <= 1'b1;
            clear_cnt  <= '0;
          end else if (term_win || proc_win) begin
            if (win_in_range) begin
              tg_we    <= 1'b1;
              tg_addr  <= win_addr;
              tg_input <= win_data;
            end else begin
              // Address and data hold their previous values on a dropped write.
              oor_drop <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          if (clear_cnt == CELLS_EXT) begin
            // Last cell was written in the cycle now ending.
            state      <= ST_IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
            clear_cnt  <= '0;
          end else begin
            tg_we     <= 1'b1;
            tg_addr   <= clear_cnt[ADDR_W-1:0];
            tg_input  <= CLEAR_CHAR;
            clear_cnt <= clear_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_write_arbiter.sv
// Self-checking bench for grid_write_arbiter: a table of hand-derived vectors,
// randomized requester traffic against a cycle-level reference model, and
// directed clear / reset-during-clear / re-trigger-during-clear sequences.
module tb_grid_write_arbiter;

  localparam int AW = 15;
  localparam int N  = 76 * 256;

  logic          pixel_clk_in = 1'b0;
  logic          rst_in       = 1'b0;
  logic          term_req     = 1'b0;
  logic [AW-1:0] term_addr    = '0;
  logic [7:0]    term_data    = '0;
  logic          proc_req     = 1'b0;
  logic [AW-1:0] proc_addr    = '0;
  logic [7:0]    proc_data    = '0;
  logic          clear_start  = 1'b0;
  logic          term_gnt, proc_gnt, clear_busy, clear_done, oor_drop, tg_we;
  logic [AW-1:0] tg_addr;
  logic [7:0]    tg_input;

  always #5 pixel_clk_in = ~pixel_clk_in;

  grid_write_arbiter dut (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .term_req     (term_req),
    .term_addr    (term_addr),
    .term_data    (term_data),
    .term_gnt     (term_gnt),
    .proc_req     (proc_req),
    .proc_addr    (proc_addr),
    .proc_data    (proc_data),
    .proc_gnt     (proc_gnt),
    .clear_start  (clear_start),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .oor_drop     (oor_drop),
    .tg_we        (tg_we),
    .tg_addr      (tg_addr),
    .tg_input     (tg_input)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_term_gnt"},   term_gnt,   0);
    check({tag, "_proc_gnt"},   proc_gnt,   0);
    check({tag, "_clear_busy"}, clear_busy, 0);
    check({tag, "_clear_done"}, clear_done, 0);
    check({tag, "_oor_drop"},   oor_drop,   0);
    check({tag, "_tg_we"},      tg_we,      0);
    check({tag, "_tg_addr"},    tg_addr,    0);
    check({tag, "_tg_input"},   tg_input,   0);
  endtask

  // ---------------- reference model ----------------
  // Clear phase: -1 = first busy cycle (no write), 0..N-1 = cycle showing write k.
  bit m_in_clear;
  int m_phase;
  bit m_done_now;
  bit m_wr_valid;
  bit m_oor_now;
  int m_wr_addr;
  int m_wr_data;
  int m_last_winner;  // 0 = terminal, 1 = processor
  bit g_t, g_p;       // expected grants in the current cycle
  int clr_writes, done_pulses, done_with_pgnt;

  task automatic model_reset();
    m_in_clear    = 1'b0;
    m_phase       = 0;
    m_done_now    = 1'b0;
    m_wr_valid    = 1'b0;
    m_oor_now     = 1'b0;
    m_wr_addr     = 0;
    m_wr_data     = 0;
    m_last_winner = 1;  // terminal takes the first tie
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    bit e_we;
    int e_addr, e_data, a, d;
    #1;
    g_t = 1'b0;
    g_p = 1'b0;
    if (!m_in_clear && !clear_start) begin
      if (term_req && proc_req) begin
`ifdef GRID_ARB_FIXED_PRIO_EN
        g_t = 1'b1;
`else
        if (m_last_winner == 1) g_t = 1'b1;
        else g_p = 1'b1;
`endif
      end else begin
        g_t = term_req;
        g_p = proc_req;
      end
    end
    e_we   = (m_in_clear && m_phase >= 0) || m_wr_valid;
    e_addr = m_in_clear ? m_phase : m_wr_addr;
    e_data = m_in_clear ? 32'h20 : m_wr_data;
    check("term_gnt",   term_gnt,   g_t);
    check("proc_gnt",   proc_gnt,   g_p);
    check("tg_we",      tg_we,      e_we);
    check("clear_busy", clear_busy, m_in_clear);
    check("clear_done", clear_done, m_done_now);
    check("oor_drop",   oor_drop,   m_oor_now);
    if (e_we) begin
      check("tg_addr",  tg_addr,  e_addr);
      check("tg_input", tg_input, e_data);
    end
    if (clear_busy === 1'b1 && tg_we === 1'b1 && tg_input === 8'h20) clr_writes++;
    if (clear_done === 1'b1) begin
      done_pulses++;
      if (proc_gnt === 1'b1) done_with_pgnt++;
    end
    // advance the model across the coming clock edge
    m_done_now = 1'b0;
    m_wr_valid = 1'b0;
    m_oor_now  = 1'b0;
    if (m_in_clear) begin
      if (m_phase == N - 1) begin
        m_in_clear = 1'b0;
        m_done_now = 1'b1;
      end else begin
        m_phase++;
      end
    end else if (clear_start) begin
      m_in_clear = 1'b1;
      m_phase    = -1;
    end else if (g_t || g_p) begin
      a = g_p ? int'(proc_addr) : int'(term_addr);
      d = g_p ? int'(proc_data) : int'(term_data);
      if (a < N) begin
        m_wr_valid = 1'b1;
        m_wr_addr  = a;
        m_wr_data  = d;
      end else begin
        m_oor_now = 1'b1;
      end
      m_last_winner = g_p ? 1 : 0;
    end
    @(negedge pixel_clk_in);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return AW'($urandom_range(N, 32767));
    return AW'($urandom_range(0, N - 1));
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit          t_req;
    logic [AW-1:0] t_addr;
    logic [7:0]  t_data;
    bit          p_req;
    logic [AW-1:0] p_addr;
    logic [7:0]  p_data;
    bit          e_tg;
    bit          e_pg;
    bit          e_we;
    logic [AW-1:0] e_addr;
    logic [7:0]  e_data;
    bit          e_oor;
  } vec_t;

  localparam int NV = 14;
  vec_t vec[NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
`ifdef GRID_ARB_FIXED_PRIO_EN
    vec[0]  = '{1, 15'd10, 8'h61, 1, 15'd20, 8'h71, 1, 0, 0, 15'd0,  8'h00, 0};
    vec[1]  = '{1, 15'd11, 8'h62, 1, 15'd20, 8'h71, 1, 0, 1, 15'd10, 8'h61, 0};
    vec[2]  = '{1, 15'd12, 8'h63, 1, 15'd20, 8'h71, 1, 0, 1, 15'd11, 8'h62, 0};
    vec[3]  = '{1, 15'd13, 8'h64, 1, 15'd20, 8'h71, 1, 0, 1, 15'd12, 8'h63, 0};
    vec[4]  = '{0, 15'd0,  8'h00, 1, 15'd20, 8'h71, 0, 1, 1, 15'd13, 8'h64, 0};
    vec[5]  = '{0, 15'd0,  8'h00, 0, 15'd0,  8'h00, 0, 0, 1, 15'd20, 8'h71, 0};
`else
    vec[0]  = '{1, 15'd10, 8'h61, 1, 15'd20, 8'h71, 1, 0, 0, 15'd0,  8'h00, 0};
    vec[1]  = '{1, 15'd11, 8'h62, 1, 15'd20, 8'h71, 0, 1, 1, 15'd10, 8'h61, 0};
    vec[2]  = '{1, 15'd11, 8'h62, 1, 15'd21, 8'h72, 1, 0, 1, 15'd20, 8'h71, 0};
    vec[3]  = '{1, 15'd12, 8'h63, 1, 15'd21, 8'h72, 0, 1, 1, 15'd11, 8'h62, 0};
    vec[4]  = '{1, 15'd12, 8'h63, 0, 15'd0,  8'h00, 1, 0, 1, 15'd21, 8'h72, 0};
    vec[5]  = '{0, 15'd0,  8'h00, 0, 15'd0,  8'h00, 0, 0, 1, 15'd12, 8'h63, 0};
`endif
    vec[6]  = '{0, 15'd0,  8'h00, 0, 15'd0,     8'h00, 0, 0, 0, 15'd0,     8'h00, 0};
    vec[7]  = '{1, 15'd5,  8'h41, 0, 15'd0,     8'h00, 1, 0, 0, 15'd0,     8'h00, 0};
    vec[8]  = '{0, 15'd0,  8'h00, 0, 15'd0,     8'h00, 0, 0, 1, 15'd5,     8'h41, 0};
    vec[9]  = '{0, 15'd0,  8'h00, 1, 15'd19456, 8'h33, 0, 1, 0, 15'd0,     8'h00, 0};
    vec[10] = '{0, 15'd0,  8'h00, 0, 15'd0,     8'h00, 0, 0, 0, 15'd0,     8'h00, 1};
    vec[11] = '{0, 15'd0,  8'h00, 1, 15'd19455, 8'h34, 0, 1, 0, 15'd0,     8'h00, 0};
    vec[12] = '{0, 15'd0,  8'h00, 0, 15'd0,     8'h00, 0, 0, 1, 15'd19455, 8'h34, 0};
    vec[13] = '{0, 15'd0,  8'h00, 0, 15'd0,     8'h00, 0, 0, 0, 15'd0,     8'h00, 0};

    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge pixel_clk_in);
    rst_in = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      term_req  = vec[i].t_req;
      term_addr = vec[i].t_addr;
      term_data = vec[i].t_data;
      proc_req  = vec[i].p_req;
      proc_addr = vec[i].p_addr;
      proc_data = vec[i].p_data;
      #1;
      check($sformatf("vec%0d_term_gnt", i), term_gnt, vec[i].e_tg);
      check($sformatf("vec%0d_proc_gnt", i), proc_gnt, vec[i].e_pg);
      check($sformatf("vec%0d_tg_we", i),    tg_we,    vec[i].e_we);
      check($sformatf("vec%0d_oor_drop", i), oor_drop, vec[i].e_oor);
      if (vec[i].e_we) begin
        check($sformatf("vec%0d_tg_addr", i),  tg_addr,  vec[i].e_addr);
        check($sformatf("vec%0d_tg_input", i), tg_input, vec[i].e_data);
      end
      @(negedge pixel_clk_in);
    end

    // Fresh reset so the model and the design start the random run aligned
    term_req = 1'b0;
    proc_req = 1'b0;
    rst_in   = 1'b0;
    @(negedge pixel_clk_in);
    rst_in = 1'b1;
    model_reset();

    // Randomized requester traffic
    for (int i = 0; i < 3000; i++) begin
      if (!term_req && $urandom_range(0, 2) == 0) begin
        term_req  = 1'b1;
        term_addr = rand_addr();
        term_data = 8'($urandom);
      end
      if (!proc_req && $urandom_range(0, 2) == 0) begin
        proc_req  = 1'b1;
        proc_addr = rand_addr();
        proc_data = 8'($urandom);
      end
      step();
      if (g_t) begin
        if ($urandom_range(0, 1) == 1) begin
          term_addr = rand_addr();
          term_data = 8'($urandom);
        end else begin
          term_req = 1'b0;
        end
      end
      if (g_p) begin
        if ($urandom_range(0, 1) == 1) begin
          proc_addr = rand_addr();
          proc_data = 8'($urandom);
        end else begin
          proc_req = 1'b0;
        end
      end
    end
    term_req = 1'b0;
    proc_req = 1'b0;
    step();
    step();

    // Full clear with a processor request waiting
    clr_writes     = 0;
    done_pulses    = 0;
    done_with_pgnt = 0;
    proc_req    = 1'b1;
    proc_addr   = 15'd7;
    proc_data   = 8'h55;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < N + 20 && done_pulses == 0; i++) begin
      step();
      if (g_p) proc_req = 1'b0;
    end
    proc_req = 1'b0;
    step();
    step();
    check("clear1_writes",      clr_writes,     N);
    check("clear1_done_pulses", done_pulses,    1);
    check("clear1_gnt_at_done", done_with_pgnt, 1);

    // Reset while the clear is at address 100
    clr_writes  = 0;
    done_pulses = 0;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 200 && !(m_in_clear && m_phase == 100); i++) step();
    #1;
    check("pre_reset_tg_we",   tg_we,   1);
    check("pre_reset_tg_addr", tg_addr, 100);
    #1;
    rst_in   = 1'b0;
    term_req = 1'b1;
    proc_req = 1'b1;
    #1;
    check_all_zero("mid_clear_reset");
    term_req = 1'b0;
    proc_req = 1'b0;
    @(negedge pixel_clk_in);
    @(negedge pixel_clk_in);
    rst_in = 1'b1;
    model_reset();
    repeat (5) step();
    check("abandoned_clear_no_done", done_pulses, 0);

    // Restart from address 0, with a second clear_start at address 50
    clr_writes  = 0;
    done_pulses = 0;
    clear_start = 1'b1;
    step();
    for (int i = 0; i < N + 20 && done_pulses == 0; i++) begin
      clear_start = (m_in_clear && m_phase == 50);
      step();
    end
    clear_start = 1'b0;
    step();
    check("clear2_writes",      clr_writes,  N);
    check("clear2_done_pulses", done_pulses, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/grid_write_arbiter.md
Name: grid_write_arbiter

Overview:
Shares the single character-grid write port (the port feeding character_sprites and text_editor) between two requesters: the keyboard-driven terminal controller and the processor MMIO writer. It also contains a clear-screen sequencer that fills the whole grid with a blank character. It sits between those requesters and the tg_we/tg_addr/tg_input bus, replacing the tie-offs on the visualizer and processor side.

Parameters:
SCREEN_WIDTH, 76, characters per row
SCREEN_HEIGHT, 256, rows in grid
CLEAR_CHAR, 8'h20, byte written by the clear sequencer
ADDR_W, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT), grid address width (derived; do not override)

Ports:
pixel_clk_in  input  1  sole clock (74.25 MHz pixel clock)
rst_in  input  1  asynchronous, active-low reset
term_req  input  1  terminal controller write request; held until granted
term_addr  input  ADDR_W  terminal write address
term_data  input  8  terminal write byte
term_gnt  output  1  one-cycle grant pulse to terminal
proc_req  input  1  processor write request; held until granted
proc_addr  input  ADDR_W  processor write address
proc_data  input  8  processor write byte
proc_gnt  output  1  one-cycle grant pulse to processor
clear_start  input  1  pulse: begin full-grid clear
clear_busy  output  1  high while the clear sequence runs
clear_done  output  1  one-cycle pulse when the clear completes
oor_drop  output  1  one-cycle pulse: granted write dropped (address out of range)
tg_we  output  1  grid write enable
tg_addr  output  ADDR_W  grid write address
tg_input  output  8  grid write data

Behaviour:
- Reset (rst_in low, asynchronous): all outputs 0; FSM in IDLE; round-robin pointer favours terminal; clear counter 0.
- FSM states: IDLE, CLEAR.
- IDLE, each cycle:
  - If clear_start is high, enter CLEAR. No grant is issued that cycle. clear_start wins over any pending req.
  - Otherwise, if only one req is high, grant it.
  - If both reqs are high, grant the requester not granted most recently. After reset, terminal wins the first tie.
  - A grant pulses term_gnt or proc_gnt for one cycle and captures that requester's addr/data into registers.
  - On the next cycle tg_we=1 with the captured addr/data. Latency is 1 cycle from grant to write.
  - At most one grant per cycle, so back-to-back grants give one write per cycle.
- Requester rule: req stays high with stable addr/data until gnt is seen. In the gnt cycle the requester may drop req, or present the next write. The arbiter samples req again the following cycle, so the same request is never granted twice.
- Out of range: if the captured addr >= SCREEN_WIDTH*SCREEN_HEIGHT, the grant still occurs, but tg_we stays 0 and oor_drop pulses in the cycle the write would have happened.
- CLEAR:
  - clear_busy=1. Writes CLEAR_CHAR to addresses 0 through N-1 (N = SCREEN_WIDTH*SCREEN_HEIGHT), one per cycle, with tg_we=1 on each; the first write is the cycle after entry.
  - No grants are issued while in CLEAR; requests wait.
  - After the write to N-1: clear_done pulses in the next cycle, clear_busy drops in that same cycle, and the FSM returns to IDLE. Pending requests are arbitrated from that cycle.
  - clear_start during CLEAR is ignored and does not restart the sequence.
- Reset mid-CLEAR or mid-write: outputs clear immediately and the sequence is abandoned, leaving the grid partially cleared. No clear_done pulse is issued.
- tg_we is never asserted on two sources in one cycle; exactly one captured source drives tg_addr/tg_input.
- Outputs tg_we/tg_addr/tg_input are registered. tg_addr/tg_input are don't-care when tg_we=0, but hold their last value.

Optional Feature:
GRID_ARB_FIXED_PRIO_EN
- Defined: fixed priority; the terminal always wins ties over the processor, and the round-robin pointer is removed.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then term_req=1, addr=5, data=8'h41 -> term_gnt in cycle 1; cycle 2: tg_we=1, tg_addr=5, tg_input=8'h41.
- term_req and proc_req both held high for 4 cycles -> grant order term, proc, term, proc; tg_we high on 4 consecutive cycles. With GRID_ARB_FIXED_PRIO_EN -> term granted every cycle while held.
- clear_start pulse with proc_req high -> exactly 19456 writes of 8'h20 to addresses 0..19455; proc_gnt is 0 throughout; clear_done pulses once, and proc_gnt follows in that same cycle.
- proc_req with addr=19456 -> proc_gnt pulses, tg_we stays 0, oor_drop pulses the next cycle.
- rst_in low at clear address 100 -> all outputs 0 asynchronously, no clear_done; a new clear_start after release restarts from address 0.
- clear_start asserted again at clear address 50 -> ignored; total write count remains 19456.
